// File: rtl/key_conditioner.sv
// Per-key conditioning of raw active-low push buttons: two-flop synchronizer, debounce,
// registered press/release edge pulses and an optional auto-repeat strobe.
module key_conditioner #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   input  logic [NUM_KEYS-1:0] repeat_enable,
   output logic [NUM_KEYS-1:0] held,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] released,
   output logic [NUM_KEYS-1:0] strobe
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_t;

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic            stage1_reg;
      logic            stage2_reg;
      logic            sync;
      logic [DW-1:0]   db_cnt_reg;
      logic            held_reg;
      logic            held_d_reg;
      logic            pressed_reg;
      logic            released_reg;
      logic            strobe_reg;
      logic            rise;
      logic            rpt_pulse;
      rpt_state_t      state_reg;
      rpt_state_t      state_next;
      logic [RW-1:0]   rpt_cnt_reg;
      logic [RW-1:0]   rpt_cnt_next;

      assign sync = ~stage2_reg;
      // rise is the same term that becomes the registered pressed pulse, so the
      // repeat phase is counted from the pressed cycle itself
      assign rise = held_reg & ~held_d_reg;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            stage1_reg   <= 1'b1;
            stage2_reg   <= 1'b1;
            db_cnt_reg   <= '0;
            held_reg     <= 1'b0;
            held_d_reg   <= 1'b0;
            pressed_reg  <= 1'b0;
            released_reg <= 1'b0;
            strobe_reg   <= 1'b0;
            state_reg    <= RPT_IDLE;
            rpt_cnt_reg  <= '0;
         end else begin
            stage1_reg <= key_n[gi];
            stage2_reg <= stage1_reg;
            if (sync == held_reg) begin
               db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
               db_cnt_reg <= '0;
               held_reg   <= ~held_reg;
            end else begin
               db_cnt_reg <= db_cnt_reg + DW'(1);
            end
            held_d_reg   <= held_reg;
            pressed_reg  <= rise;
            released_reg <= ~held_reg & held_d_reg;
            strobe_reg   <= rise | (rpt_pulse & repeat_enable[gi]);
            state_reg    <= state_next;
            rpt_cnt_reg  <= rpt_cnt_next;
         end
      end

      always_comb begin
         state_next   = state_reg;
         rpt_cnt_next = rpt_cnt_reg;
         rpt_pulse    = 1'b0;
         case (state_reg)
            RPT_IDLE: begin
               if (rise) begin
                  state_next   = RPT_DELAY;
                  rpt_cnt_next = '0;
               end
            end
            RPT_DELAY: begin
               if (!held_reg) begin
                  state_next   = RPT_IDLE;
                  rpt_cnt_next = '0;
               end else if (rpt_cnt_reg == DELAY_LAST) begin
                  rpt_pulse    = 1'b1;
                  state_next   = RPT_REPEAT;
                  rpt_cnt_next = '0;
               end else begin
                  rpt_cnt_next = rpt_cnt_reg + RW'(1);
               end
            end
            RPT_REPEAT: begin
               if (!held_reg) begin
                  state_next   = RPT_IDLE;
                  rpt_cnt_next = '0;
               end else if (rpt_cnt_reg == PERIOD_LAST) begin
                  rpt_pulse    = 1'b1;
                  rpt_cnt_next = '0;
               end else begin
                  rpt_cnt_next = rpt_cnt_reg + RW'(1);
               end
            end
            default: begin
               state_next   = RPT_IDLE;
               rpt_cnt_next = '0;
            end
         endcase
      end

      assign held[gi]     = held_reg;
      assign pressed[gi]  = pressed_reg;
      assign released[gi] = released_reg;
      assign strobe[gi]   = strobe_reg;
   end

endmodule
